// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch unit with halfword prefetch queue
//
// Purpose: fetches 32-bit words from the shared memory port, splits each into
// two 16-bit instructions tagged with their PCs, buffers them in a small FIFO
// and presents them one at a time to the execute side. Jump redirects flush
// the queue and invalidate any read still in flight.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   o_mem_req/o_mem_addr  word read request (held until i_mem_ack)
//   i_mem_ack/i_mem_data  read completion, little-endian halfwords
//   o_valid/o_ir/o_pc     head-of-queue instruction and its address
//   i_ready               consumer accepts head when o_valid & i_ready
//   i_redirect(_pc)       jump taken; flush and refetch from target

module ifetch_queue #(
  parameter int unsigned QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic        o_valid,
  output logic [15:0] o_ir,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [PW-1:0] head_q, head_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   ir_q [QDEPTH];
  logic [15:0]   ir_d [QDEPTH];
  logic [31:0]   pc_q [QDEPTH];
  logic [31:0]   pc_d [QDEPTH];

  logic          deq;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] n_enq;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail1;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    head_d     = head_q;
    count_d    = count_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    n_enq      = '0;

    deq        = (count_q != '0) && i_ready;
    // Free slots use the pre-dequeue count so a same-cycle pop never
    // lets a request be issued that could overflow.
    free_slots = DEPTH_C - count_q;
    tail       = head_q + count_q[PW-1:0];
    tail1      = tail + PW'(1);

    case (state_q)
      ST_IDLE: begin
        if (!i_redirect && free_slots >= TWO_C) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          if (i_redirect) begin
            state_d = ST_IDLE;
          end else begin
            // req_addr_q is the word being read; fetch_pc_q[1] says whether
            // the lower halfword is part of the stream (odd jump target).
            if (!fetch_pc_q[1]) begin
              pc_d[tail]  = req_addr_q;
              ir_d[tail]  = i_mem_data[15:0];
              pc_d[tail1] = req_addr_q + 32'd2;
              ir_d[tail1] = i_mem_data[31:16];
              n_enq       = CW'(2);
            end else begin
              pc_d[tail]  = req_addr_q + 32'd2;
              ir_d[tail]  = i_mem_data[31:16];
              n_enq       = CW'(1);
            end
            fetch_pc_d = req_addr_q + 32'd4;
            state_d    = ((free_slots - n_enq) >= TWO_C) ? ST_REQ : ST_IDLE;
          end
        end else if (i_redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        // The stale read must still complete; its data is thrown away.
        if (i_mem_ack) begin
          state_d = (!i_redirect && free_slots >= TWO_C) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_redirect) fetch_pc_d = i_redirect_pc & ~32'h1;

    head_d  = head_q + PW'(deq);
    count_d = count_q - CW'(deq) + n_enq;
    if (i_redirect) count_d = '0;

    // The address is frozen while a read is outstanding (including a dropped
    // one); otherwise it follows the next word to fetch.
    if ((state_q != ST_IDLE) && !i_mem_ack) begin
      req_addr_d = req_addr_q;
    end else begin
      req_addr_d = fetch_pc_d & ~32'h3;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC & ~32'h3;
      head_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        ir_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      head_q     <= head_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
    end
  end

  assign o_mem_req  = (state_q != ST_IDLE);
  assign o_mem_addr = req_addr_q;
  assign o_valid    = (count_q != '0);
  assign o_ir       = o_valid ? ir_q[head_q] : 16'h0000;
  // With the queue empty, o_pc shows the next address to be fetched.
  assign o_pc       = o_valid ? pc_q[head_q] : fetch_pc_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue

module tb_ifetch_queue;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        i_clk, i_rst;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
  logic        o_valid;
  logic [15:0] o_ir;
  logic [31:0] o_pc;
  logic        i_ready, i_redirect;
  logic [31:0] i_redirect_pc;

  ifetch_queue #(.QDEPTH(4), .RESET_PC(RPC)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .o_valid(o_valid), .o_ir(o_ir), .o_pc(o_pc),
    .i_ready(i_ready), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [5];

  int checks, errors, cyc;
  int resp_lat, cur_rand, wait_cnt;
  bit rand_lat, busy, redir_prev, inflight;
  logic [31:0] hold_addr, exp_pc, cpc;
  logic [31:0] ack_q [$];
  logic [31:0] got_pc [$];
  logic [15:0] got_ir [$];
  int          got_cyc [$];
  int g0, a0, k, span, lat_l;

  function automatic logic [15:0] ir_of(input logic [31:0] pc);
    case (pc)
      32'h100: return 16'hAAAA;
      32'h102: return 16'hBBBB;
      32'h104: return 16'hCCCC;
      32'h106: return 16'hDDDD;
      default: return pc[15:0] ^ pc[31:16] ^ 16'h9E37;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // One clock: reference model and memory responder act at the falling edge,
  // the caller regains control 1 time unit after the rising edge.
  task automatic tick();
    @(negedge i_clk);
    cyc++;
    if (i_rst) begin
      exp_pc     = RPC;
      redir_prev = 1'b0;
      busy       = 1'b0;
      i_mem_ack  = 1'b0;
    end else begin
      if (redir_prev) check("valid_after_redirect", 32'(o_valid), 32'd0);
      if (o_valid && i_ready) begin
        check("deliver_pc", o_pc, exp_pc);
        check("deliver_ir", 32'(o_ir), 32'(ir_of(exp_pc)));
        got_pc.push_back(o_pc);
        got_ir.push_back(o_ir);
        got_cyc.push_back(cyc);
        exp_pc = exp_pc + 32'd2;
      end
      if (i_redirect) exp_pc = i_redirect_pc & ~32'h1;
      redir_prev = i_redirect;

      if (busy) check("req_held", 32'(o_mem_req), 32'd1);
      if (o_mem_req) begin
        if (!busy) begin
          busy      = 1'b1;
          wait_cnt  = 0;
          hold_addr = o_mem_addr;
          check("addr_align", 32'(o_mem_addr[1:0]), 32'd0);
        end else begin
          check("addr_stable", o_mem_addr, hold_addr);
        end
        if (wait_cnt >= (rand_lat ? cur_rand : resp_lat)) begin
          i_mem_ack  = 1'b1;
          i_mem_data = {ir_of(hold_addr + 32'd2), ir_of(hold_addr)};
          ack_q.push_back(hold_addr);
          busy       = 1'b0;
          cur_rand   = $urandom_range(0, 3);
        end else begin
          i_mem_ack  = 1'b0;
          i_mem_data = $urandom;
          wait_cnt++;
        end
      end else begin
        i_mem_ack  = 1'b0;
        i_mem_data = $urandom;
        busy       = 1'b0;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst      = 1'b1;
    i_redirect = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    resp_lat = 0; rand_lat = 1'b0; cur_rand = 0; wait_cnt = 0; busy = 1'b0;
    hold_addr = '0; exp_pc = RPC; redir_prev = 1'b0;
    i_rst = 1'b1; i_mem_ack = 1'b0; i_mem_data = '0;
    i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;

    vecs[0] = '{32'h0000_0203, 1, 32'h0000_0202, 32'h0000_0200, 32'h0000_0204};
    vecs[1] = '{32'h0000_0301, 0, 32'h0000_0300, 32'h0000_0300, 32'h0000_0304};
    vecs[2] = '{32'hFFFF_FFFC, 2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[4] = '{32'h0000_0056, 3, 32'h0000_0056, 32'h0000_0054, 32'h0000_0058};

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_pc", o_pc, RPC);
    check("rst_ir", 32'(o_ir), 32'd0);

    // Backpressure: two acks fill the queue, then fetch stalls
    resp_lat = 0;
    i_rst = 1'b0;
    repeat (10) tick();
    check("bp_acks", 32'(ack_q.size()), 32'd2);
    if (ack_q.size() >= 2) begin
      check("bp_ack0", ack_q[0], 32'h100);
      check("bp_ack1", ack_q[1], 32'h104);
    end
    check("bp_req", 32'(o_mem_req), 32'd0);
    check("bp_valid", 32'(o_valid), 32'd1);
    check("bp_pc", o_pc, 32'h100);
    check("bp_ir", 32'(o_ir), 32'h0000AAAA);
    resp_lat = 100;
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    check("bp_pc1", o_pc, 32'h102);
    check("bp_noreq1", 32'(o_mem_req), 32'd0);
    repeat (3) tick();
    check("bp_noreq2", 32'(o_mem_req), 32'd0);
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    for (int n = 0; n < 5 && !o_mem_req; n++) tick();
    check("bp_req_up", 32'(o_mem_req), 32'd1);
    check("bp_req_addr", o_mem_addr, 32'h108);

    // Asynchronous reset while the request is outstanding
    i_rst = 1'b1;
    #1;
    check("arst_req", 32'(o_mem_req), 32'd0);
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_pc", o_pc, RPC);
    tick();
    i_rst = 1'b0;
    resp_lat = 3;
    for (int n = 0; n < 5 && !o_mem_req; n++) tick();
    check("post_rst_addr", o_mem_addr, 32'h100);

    // Linear fetch with ack latency 0 and 3
    for (int t = 0; t < 2; t++) begin
      lat_l = (t == 0) ? 0 : 3;
      do_reset();
      resp_lat = lat_l;
      i_ready = 1'b1;
      g0 = got_pc.size();
      i_rst = 1'b0;
      for (int n = 0; n < 40 && got_pc.size() < g0 + 4; n++) tick();
      if (got_pc.size() < g0 + 4) begin
        check("lin_timeout", 32'(got_pc.size() - g0), 32'd4);
      end else begin
        for (int j = 0; j < 4; j++) begin
          check("lin_pc", got_pc[g0 + j], 32'h100 + 32'(2 * j));
        end
        check("lin_ir0", 32'(got_ir[g0]), 32'h0000AAAA);
        check("lin_ir1", 32'(got_ir[g0 + 1]), 32'h0000BBBB);
        check("lin_ir2", 32'(got_ir[g0 + 2]), 32'h0000CCCC);
        check("lin_ir3", 32'(got_ir[g0 + 3]), 32'h0000DDDD);
        span = got_cyc[g0 + 3] - got_cyc[g0];
        check("lin_span", 32'(span), 32'((lat_l + 2 > 3) ? lat_l + 2 : 3));
      end
    end

    // Redirect while the read at 0x104 is in flight
    do_reset();
    resp_lat = 2;
    i_ready = 1'b0;
    i_rst = 1'b0;
    for (int n = 0; n < 20 && !(o_mem_req && o_mem_addr == 32'h104); n++) tick();
    resp_lat = 100;
    check("rdf_pending", o_mem_addr, 32'h104);
    tick();
    a0 = ack_q.size();
    g0 = got_pc.size();
    i_redirect = 1'b1; i_redirect_pc = 32'h203;
    tick();
    i_redirect = 1'b0;
    check("rdf_valid", 32'(o_valid), 32'd0);
    tick();
    resp_lat = 0;
    i_ready = 1'b1;
    for (int n = 0; n < 20 && (ack_q.size() < a0 + 2 || got_pc.size() < g0 + 1); n++) tick();
    if (ack_q.size() < a0 + 2 || got_pc.size() < g0 + 1) begin
      check("rdf_timeout", 32'(ack_q.size() - a0), 32'd2);
    end else begin
      check("rdf_dropped_addr", ack_q[a0], 32'h104);
      check("rdf_next_addr", ack_q[a0 + 1], 32'h200);
      check("rdf_first_pc", got_pc[g0], 32'h202);
      check("rdf_first_ir", 32'(got_ir[g0]), 32'(ir_of(32'h202)));
    end

    // Redirect coinciding with an ack and a handshake
    do_reset();
    resp_lat = 1;
    i_ready = 1'b1;
    i_rst = 1'b0;
    for (int n = 0; n < 20 && !(o_mem_req && o_valid); n++) tick();
    check("rca_setup", 32'(o_mem_req && o_valid), 32'd1);
    resp_lat = 0;
    cpc = o_pc;
    a0 = ack_q.size();
    g0 = got_pc.size();
    i_redirect = 1'b1; i_redirect_pc = 32'h400;
    tick();
    i_redirect = 1'b0;
    check("rca_consumed_cnt", 32'(got_pc.size() - g0), 32'd1);
    if (got_pc.size() > g0) check("rca_consumed_pc", got_pc[g0], cpc);
    check("rca_ack_cnt", 32'(ack_q.size() - a0), 32'd1);
    check("rca_empty", 32'(o_valid), 32'd0);
    for (int n = 0; n < 20 && got_pc.size() < g0 + 2; n++) tick();
    if (got_pc.size() < g0 + 2) check("rca_timeout", 32'(got_pc.size() - g0), 32'd2);
    else check("rca_next_pc", got_pc[g0 + 1], 32'h400);

    // Table of redirect targets, including odd halfwords and wrap-around
    for (int v = 0; v < 5; v++) begin
      resp_lat = vecs[v].lat;
      i_ready = 1'b0;
      inflight = o_mem_req;
      a0 = ack_q.size();
      g0 = got_pc.size();
      i_redirect = 1'b1; i_redirect_pc = vecs[v].target;
      tick();
      i_redirect = 1'b0;
      i_ready = 1'b1;
      k = a0 + (inflight ? 1 : 0);
      for (int n = 0; n < 60 && (got_pc.size() < g0 + 2 || ack_q.size() < k + 2); n++) tick();
      if (got_pc.size() < g0 + 2 || ack_q.size() < k + 2) begin
        check("vec_timeout", 32'(v), 32'hFFFFFFFF);
      end else begin
        check("vec_first_pc", got_pc[g0], vecs[v].exp_pc);
        check("vec_first_ir", 32'(got_ir[g0]), 32'(ir_of(vecs[v].exp_pc)));
        check("vec_second_pc", got_pc[g0 + 1], vecs[v].exp_pc + 32'd2);
        check("vec_addr", ack_q[k], vecs[v].exp_addr);
        check("vec_next_addr", ack_q[k + 1], vecs[v].exp_next);
      end
    end

    // Random traffic against the stream model
    rand_lat = 1'b1;
    g0 = got_pc.size();
    for (int n = 0; n < 3000; n++) begin
      i_ready = ($urandom_range(0, 9) < 7);
      i_redirect = ($urandom_range(0, 39) == 0);
      i_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      tick();
    end
    i_redirect = 1'b0;
    check("rand_progress", 32'(got_pc.size() - g0 > 500), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
